// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one registered-read sprite ROM between two requesters,
// tagging returned data by requester and masking out-of-range reads as transparent.
module sprite_rom_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 5,
    parameter int DEPTH = 11550,
    parameter logic [DATA_W-1:0] TRANSPARENT = '0,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    logic              last_q, last_d;
    logic              a_vld_q, a_vld_d, a_id_q, a_id_d, a_oob_q, a_oob_d;
    logic              b_vld_q, b_vld_d, b_id_q, b_id_d, b_oob_q, b_oob_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, sel_addr;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        // requester 0 wins a tie only under fixed priority or when 1 was served last
        gnt0       = !Reset && req0 && (!req1 || FIXED_PRIO || last_q);
        gnt1       = !Reset && req1 && !gnt0;
        last_d     = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
        sel_addr   = gnt1 ? addr1 : addr0;
        a_vld_d    = gnt0 || gnt1;
        a_id_d     = gnt1;
        a_oob_d    = 32'(sel_addr) >= $unsigned(DEPTH);
        rom_addr_d = (a_vld_d && !a_oob_d) ? sel_addr : rom_addr_q;
        b_vld_d    = a_vld_q;
        b_id_d     = a_id_q;
        b_oob_d    = a_oob_q;
        ret_data   = b_oob_q ? TRANSPARENT : rom_data;
        rvalid0    = b_vld_q && !b_id_q;
        rvalid1    = b_vld_q && b_id_q;
        rdata0     = rvalid0 ? ret_data : '0;
        rdata1     = rvalid1 ? ret_data : '0;
        rom_addr   = rom_addr_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q     <= 1'b1;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            rom_addr_q <= '0;
            a_id_q     <= 1'b0;
            a_oob_q    <= 1'b0;
            b_id_q     <= 1'b0;
            b_oob_q    <= 1'b0;
        end else begin
            last_q     <= last_d;
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            rom_addr_q <= rom_addr_d;
            a_id_q     <= a_id_d;
            a_oob_q    <= a_oob_d;
            b_id_q     <= b_id_d;
            b_oob_q    <= b_oob_d;
        end
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM between two pixel requesters, e.g. left/right goal renderers, or renderer plus collision probe.
- The ROM has a registered read: data appears one cycle after the address is presented.
- Grants one request per cycle, registers the winning address onto the ROM bus, and returns data tagged to the correct requester.
- Addresses outside the sprite image never reach the ROM and return the transparent colour index instead.

Parameters:
ADDR_W, 14, width of ROM and requester address buses
DATA_W, 5, width of palette index returned by ROM
DEPTH, 11550, number of valid ROM words; legal addresses 0..DEPTH-1
TRANSPARENT, 0, palette index returned for out-of-range addresses
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always wins

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 read request, level
addr0  input  ADDR_W  requester 0 word address, valid while req0=1
gnt0  output  1  requester 0 request accepted this cycle (combinational)
rvalid0  output  1  rdata0 valid this cycle
rdata0  output  DATA_W  requester 0 read data
req1  input  1  requester 1 read request, level
addr1  input  ADDR_W  requester 1 word address
gnt1  output  1  requester 1 accepted this cycle
rvalid1  output  1  rdata1 valid this cycle
rdata1  output  DATA_W  requester 1 read data
rom_addr  output  ADDR_W  registered address to the ROM's read_address
rom_data  input  DATA_W  ROM data_Out, valid one cycle after rom_addr

Behaviour:
- Reset values (synchronous, Reset=1 at a rising edge):
  - rom_addr=0.
  - Pipeline valid bits (stage A, stage B) = 0, so rvalid0 and rvalid1 are 0 in the following cycle.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- Reset mid-operation: in-flight reads are discarded; no rvalid may fire for a request granted before reset.
- gnt0/gnt1 are 0 while Reset=1.
- Arbitration, combinational each cycle:
  - Only one requester asserting: it is granted.
  - Both asserting, FIXED_PRIO=0: grant the one not equal to last.
  - Both asserting, FIXED_PRIO=1: grant requester 0.
  - gnt0 and gnt1 are never both 1.
  - last updates to the granted id on each grant and holds otherwise.
- Handshake:
  - A requester holds req and addr stable until it sees gnt high in the same cycle.
  - Keeping req high after a grant starts a new request; back-to-back grants at one per cycle are allowed.
  - Dropping req without a grant is legal; nothing is issued.
  - No backpressure on the return path.
- Pipeline, grant in cycle k:
  - Edge k+1:
    - Stage A captures valid=1, id, and oob=(addr >= DEPTH).
    - rom_addr captures the address if oob=0; rom_addr holds its previous value if oob=1 or there is no grant.
  - Edge k+2:
    - Stage B captures stage A.
    - The ROM registers data for rom_addr.
  - Cycle k+2:
    - rvalid[id]=1.
    - rdata[id]=TRANSPARENT if oob, else rom_data.
  - Fixed latency of 2 cycles from grant to rvalid, including out-of-range requests.
- Non-selected rdata output drives 0; rvalid0 and rvalid1 are never both 1.
- Throughput is one read per cycle across both requesters. Sustained contention under round-robin strictly alternates 0,1,0,1.
- Address compare is unsigned and full-width. DEPTH-1 is legal; DEPTH and above are out of range.

Test Plan:
- Reset then req0=1, addr0=0x0005 for one cycle -> gnt0=1 same cycle; rom_addr=0x0005 next cycle; rvalid0=1 with rdata0=mem[5] exactly 2 cycles after grant; rvalid1 stays 0.
- req0 and req1 both held 6 cycles, FIXED_PRIO=0 -> grants 0,1,0,1,0,1; rvalid pattern is the same sequence shifted by 2 cycles; each rdata matches its own address.
- FIXED_PRIO=1, both requesting 4 cycles -> gnt0=1 every cycle, gnt1=0; releasing req0 -> gnt1=1 in that same cycle.
- req1 with addr1=11549, then addr1=11550, then 0x3FFF -> first returns mem[11549]; second and third return 0 (TRANSPARENT) with 2-cycle latency; rom_addr stays 11549 throughout.
- Grant req0 in cycle k, assert Reset in cycle k+1 -> no rvalid0 in k+2 or later; rom_addr=0; next tie after reset goes to requester 0.
- Back-to-back req0 with addr 10,11,12,13 -> four consecutive rvalid0 cycles carrying mem[10..13] in order, no gaps.
